// File: rtl/router_ctrl.sv
// router_ctrl: ingress FSM for the 1x3 router with parity check and per-FIFO unread timeout
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_en,
    output logic       busy,
    output logic [2:0] wr_en,
    output logic       lfd_state,
    output logic [7:0] data_out,
    output logic [2:0] vld_out,
    output logic [2:0] soft_rst,
    output logic       err
);
    localparam logic [2:0] DECODE       = 3'd0;
    localparam logic [2:0] LOAD_FIRST   = 3'd1;
    localparam logic [2:0] LOAD_DATA    = 3'd2;
    localparam logic [2:0] CHECK_PARITY = 3'd3;
    localparam logic [2:0] WAIT_EMPTY   = 3'd4;
    localparam logic [2:0] DROP         = 3'd5;
    logic [2:0] state, next_state;
    logic [1:0] addr;
    logic [7:0] hdr, calc, rx_par;
    logic [CNT_W-1:0] cnt [3];
    logic [3:0] empty_x, full_x;
    logic [2:0] sel;
    logic stall;
    assign empty_x = {1'b0, fifo_empty};
    assign full_x = {1'b0, fifo_full};
    assign sel = 3'b001 << addr;
    assign stall = full_x[addr];
    assign vld_out = ~fifo_empty;

    // next state plus the handshake and FIFO write strobes for the current state
    always_comb begin
        next_state = state;
        busy = 1'b0;
        wr_en = 3'b000;
        lfd_state = 1'b0;
        data_out = data_in;
        case (state)
            DECODE:
                if (pkt_valid)
                    next_state = (data_in[1:0] == 2'd3) ? DROP :
                                 (empty_x[data_in[1:0]] ? LOAD_FIRST : WAIT_EMPTY);
            WAIT_EMPTY: begin
                busy = 1'b1;
                next_state = empty_x[addr] ? LOAD_FIRST : WAIT_EMPTY;
            end
            LOAD_FIRST: begin
                busy = 1'b1;
                wr_en = sel;
                lfd_state = 1'b1;
                data_out = hdr;
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = stall;
                wr_en = stall ? 3'b000 : sel;
                next_state = (!stall && !pkt_valid) ? CHECK_PARITY : LOAD_DATA;
            end
            CHECK_PARITY: begin
                busy = 1'b1;
                next_state = DECODE;
            end
            DROP:
                next_state = pkt_valid ? DROP : DECODE;
            default:
                next_state = DECODE;
        endcase
    end

    // state register, header capture, running parity and registered error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DECODE;
            addr <= 2'd0;
            hdr <= 8'd0;
            calc <= 8'd0;
            rx_par <= 8'd0;
            err <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                DECODE:
                    if (pkt_valid && data_in[1:0] != 2'd3) begin
                        hdr <= data_in;
                        addr <= data_in[1:0];
                        err <= 1'b0;
                    end
                LOAD_FIRST:
                    calc <= hdr;
                LOAD_DATA:
                    if (!stall) begin
                        if (pkt_valid)
                            calc <= calc ^ data_in;
                        else
                            rx_par <= data_in;
                    end
                CHECK_PARITY:
                    err <= (calc != rx_par);
                default: ;
            endcase
        end
    end

    // per-channel count of unread non-empty cycles; pulse soft_rst on the TIMEOUT-th
    always_ff @(posedge clk) begin
        if (!rst) begin
            soft_rst <= 3'b000;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                soft_rst[i] <= 1'b0;
                if (fifo_empty[i] || read_en[i])
                    cnt[i] <= '0;
                else if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
                    cnt[i] <= '0;
                    soft_rst[i] <= 1'b1;
                end else
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: scoreboard bench for router_ctrl; writes are checked by a monitor against a queue
module tb_router_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] read_en = 3'b000;
    logic       busy, lfd_state, err;
    logic [2:0] wr_en, vld_out, soft_rst;
    logic [7:0] data_out;
    logic [11:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    router_ctrl dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_en(read_en),
        .busy(busy), .wr_en(wr_en), .lfd_state(lfd_state), .data_out(data_out),
        .vld_out(vld_out), .soft_rst(soft_rst), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every FIFO write must match the next expected {wr_en, lfd_state, data_out}
    always @(negedge clk) begin
        if (rst && wr_en != 3'b000) begin
            if (exp_q.size() == 0)
                chk("unexpected_write", {20'd0, wr_en, lfd_state, data_out}, 32'd0);
            else
                chk("write", {20'd0, wr_en, lfd_state, data_out}, {20'd0, exp_q.pop_front()});
        end
    end

    task automatic expect_wr(input logic [1:0] a, input logic l, input logic [7:0] d);
        if (a != 2'd3) exp_q.push_back({3'b001 << a, l, d});
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        int n = 0;
        pkt_valid = v;
        data_in = d;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("accept_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] base, input logic bad, input int stall_at);
        logic [1:0] a = h[1:0];
        logic [7:0] p = h;
        logic [7:0] b;
        int len = int'(h[7:2]);
        expect_wr(a, 1'b1, h);
        send(1'b1, h);
        if (a != 2'd3) chk("err_clear_on_hdr", {31'd0, err}, 32'd0);
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            p = p ^ b;
            if (i == stall_at) begin
                pkt_valid = 1'b1;
                data_in = b;
                fifo_full = 3'b001 << a;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_busy", {31'd0, busy}, 32'd1);
                    chk("stall_wr_en", {29'd0, wr_en}, 32'd0);
                    @(posedge clk);
                    #1;
                end
                fifo_full = 3'b000;
            end
            expect_wr(a, 1'b0, b);
            send(1'b1, b);
        end
        if (bad) p = ~p;
        expect_wr(a, 1'b0, p);
        send(1'b0, p);
        pkt_valid = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic finish_pkt(input logic e);
        chk("parity_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("err", {31'd0, err}, {31'd0, e});
        chk("back_to_decode", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_en", {29'd0, wr_en}, 32'd0);
        chk("rst_lfd", {31'd0, lfd_state}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_soft_rst", {29'd0, soft_rst}, 32'd0);
        chk("rst_vld_out", {29'd0, vld_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(8'h0D, 8'h11, 1'b0, -1);
        finish_pkt(1'b0);
        send_pkt(8'h0D, 8'h11, 1'b1, -1);
        finish_pkt(1'b1);
        send_pkt(8'h02, 8'h00, 1'b0, -1);
        finish_pkt(1'b0);
        fifo_empty = 3'b110;
        expect_wr(2'd0, 1'b1, 8'h04);
        send(1'b1, 8'h04);
        pkt_valid = 1'b1;
        data_in = 8'h55;
        repeat (4) begin
            @(negedge clk);
            chk("wait_empty_busy", {31'd0, busy}, 32'd1);
            chk("wait_empty_vld_out", {29'd0, vld_out}, 32'd1);
            @(posedge clk);
            #1;
        end
        fifo_empty = 3'b111;
        expect_wr(2'd0, 1'b0, 8'h55);
        send(1'b1, 8'h55);
        expect_wr(2'd0, 1'b0, 8'h51);
        send(1'b0, 8'h51);
        pkt_valid = 1'b0;
        finish_pkt(1'b0);
        send_pkt(8'h12, 8'hA0, 1'b0, 1);
        finish_pkt(1'b0);
        send_pkt(8'h0B, 8'hC0, 1'b0, -1);
        chk("drop_back_decode", {31'd0, busy}, 32'd0);
        send_pkt(8'h05, 8'h77, 1'b0, -1);
        finish_pkt(1'b0);
        fifo_empty = 3'b011;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk("timeout_soft_rst", {29'd0, soft_rst}, (k == 30) ? 32'd4 : 32'd0);
        end
        fifo_empty = 3'b111;
        @(posedge clk);
        #1;
        fifo_empty = 3'b011;
        for (int k = 1; k <= 60; k++) begin
            read_en = (k == 29) ? 3'b100 : 3'b000;
            @(posedge clk);
            #1;
            chk("restart_soft_rst", {29'd0, soft_rst}, (k == 59) ? 32'd4 : 32'd0);
        end
        read_en = 3'b000;
        fifo_empty = 3'b111;
        @(posedge clk);
        #1;
        expect_wr(2'd1, 1'b1, 8'h0D);
        send(1'b1, 8'h0D);
        expect_wr(2'd1, 1'b0, 8'h41);
        send(1'b1, 8'h41);
        rst = 1'b0;
        pkt_valid = 1'b1;
        data_in = 8'h42;
        @(posedge clk);
        #1;
        chk("midrst_wr_en", {29'd0, wr_en}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_lfd", {31'd0, lfd_state}, 32'd0);
        pkt_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_pkt(8'h09, 8'h60, 1'b0, -1);
        finish_pkt(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
Ingress controller for the 1x3 packet router. It frames incoming byte packets, decodes the destination, and sequences writes (including the header-marking lfd_state) into one of three 16x9 output FIFOs. It also checks packet parity, and soft-resets any output FIFO whose data sits unread too long. It sits between the packet source and the three FIFOs; FIFO full/empty flags feed back into it.

Parameters:
TIMEOUT, 30, consecutive unread cycles with a non-empty FIFO before soft_rst fires
CNT_W, 5, width of each per-channel timeout counter (must hold TIMEOUT-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset
pkt_valid  input  1  high during header and payload bytes; low on the parity byte
data_in  input  8  packet byte; header = {len[5:0], addr[1:0]}
fifo_full  input  3  full flag per FIFO
fifo_empty  input  3  empty flag per FIFO
read_en  input  3  per-FIFO read enable from the downstream consumer
busy  output  1  source must hold data_in and pkt_valid while high
wr_en  output  3  one-hot FIFO write enable
lfd_state  output  1  high only on the header write
data_out  output  8  byte to FIFO din
vld_out  output  3  = ~fifo_empty, combinational
soft_rst  output  3  one-cycle soft-reset pulse per FIFO
err  output  1  registered parity-error flag

Behaviour:
- Reset (rst=0 at clk edge):
  - state=DECODE; counters, addr, hdr, calc, rx_par cleared.
  - err=0 and soft_rst=0.
  - Combinational outputs follow from state DECODE: busy=0, wr_en=0, lfd_state=0.
  - A reset mid-packet abandons the packet; no further writes occur.
- Byte acceptance: a byte is accepted when busy=0 in DECODE, LOAD_DATA, or DROP. Any byte presented while busy=1 is not consumed.
- DECODE (busy=0):
  - On pkt_valid with data_in[1:0]==3: go to DROP; nothing written.
  - On pkt_valid with data_in[1:0]<3: hdr<=data_in, addr<=data_in[1:0], err<=0. Next state is LOAD_FIRST if fifo_empty[addr], else WAIT_EMPTY.
- WAIT_EMPTY (busy=1): go to LOAD_FIRST when fifo_empty[addr]=1.
- LOAD_FIRST (busy=1):
  - wr_en[addr]=1, lfd_state=1, data_out=hdr, calc<=hdr.
  - Next state LOAD_DATA.
- LOAD_DATA (busy=fifo_full[addr]):
  - data_out=data_in; wr_en[addr]=~fifo_full[addr].
  - Accepted byte with pkt_valid=1: calc<=calc^data_in; stay in LOAD_DATA.
  - Accepted byte with pkt_valid=0 (parity byte): byte is written, rx_par<=data_in, go to CHECK_PARITY.
  - Zero-length payload (parity immediately after header) is legal.
- CHECK_PARITY (busy=1): err<=(calc!=rx_par); go to DECODE.
- DROP (busy=0): consumes bytes; the first cycle with pkt_valid=0 (parity byte) returns to DECODE.
- Write timing: write occurs on the same edge as acceptance; wr_en is never asserted when fifo_full[addr]=1. Single-byte latency from accept to FIFO write edge.
- Timeout, per channel i:
  - cnt[i] clears when fifo_empty[i] or read_en[i].
  - Otherwise cnt[i] increments.
  - When cnt[i]==TIMEOUT-1 and the increment condition holds: soft_rst[i]<=1 for one cycle and cnt[i]<=0.
  - Result: the pulse follows the TIMEOUT-th consecutive unread non-empty cycle.
- Soft reset of the target FIFO mid-packet does not alter the FSM.
- Simultaneous events: the three timeout channels are independent; a soft_rst on a channel has no effect on writes to other channels.

Test Plan:
- Reset, then header 0x0D (len 3, addr 1) + 3 payload bytes + correct parity, FIFO1 empty -> wr_en=3'b010 for 5 cycles, lfd_state only on the header cycle, data_out 0x0D first, err=0, FSM back in DECODE.
- Same packet with wrong parity byte -> err=1 one cycle after the parity write; err clears on the next accepted header.
- Header to addr 0 while fifo_empty[0]=0 -> busy=1 held until fifo_empty[0]=1, then header written with lfd_state=1.
- fifo_full[addr] asserted mid-payload for 4 cycles -> busy=1 and wr_en=0 for those 4 cycles; no byte lost or duplicated.
- Header 0x0B (addr 3) -> no wr_en for the whole packet; DECODE reached after the parity byte.
- fifo_empty[2]=0 and read_en[2]=0 for 30 cycles -> single soft_rst[2] pulse; a read_en[2] pulse at cycle 29 restarts the count with no pulse; rst=0 mid-payload -> wr_en=0 and busy=0 on the next cycle.
